acc_out_pack: RTL and testbench
===============================

ACC_OUT_PACK -- requirements
Module: acc_out_pack

Interface
REQ-001 Parameter DATA_W, default 32, input data width in bits.
REQ-002 Parameter NCH, default 4, number of independent channels (power of 2, >=2); CH_W = log2(NCH).
REQ-003 Parameter PACK_N, default 2, input beats per output word; OUT_W = PACK_N*DATA_W.
REQ-004 Parameter SAT, default 1: 1 = saturating accumulate, 0 = wrap-around accumulate.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 mode  input  1  0 = ACC (sum beats), 1 = PACK (concatenate beats); quasi-static, changed only with clear.
REQ-008 clear  input  1  synchronous clear of all channel state.
REQ-009 flush  input  1  single-cycle pulse, emit every non-empty channel.
REQ-010 in_valid  input  1  input beat valid.
REQ-011 in_ready  output  1  block accepts beat this cycle.
REQ-012 in_data  input  DATA_W  unsigned operand.
REQ-013 in_ch  input  CH_W  target channel.
REQ-014 in_last  input  1  final beat of channel's group; emit result.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 out_data  output  OUT_W  result word.
REQ-018 out_ch  output  CH_W  channel of result.
REQ-019 out_ovf  output  1  ACC: sum overflowed OUT_W; PACK: always 0.
REQ-020 busy  output  1  high while FSM in FLUSH.

Function
REQ-021 Beat accepted iff in_valid & in_ready; in_ready = (state==RUN) & ~clear & (~out_valid | out_ready), combinational.
REQ-022 Per channel: OUT_W accumulator, lane counter 0..PACK_N-1, non-empty flag, sticky overflow flag.
REQ-023 ACC: acc[ch] <= acc[ch] + zero-extended in_data; on carry out of OUT_W, overflow flag set, acc = all-ones if SAT=1, truncated sum if SAT=0.
REQ-024 PACK: in_data written to lane lane_cnt[ch] (lane 0 = bits DATA_W-1:0), lane_cnt increments.
REQ-025 Emit when accepted beat has in_last, or in PACK when lane_cnt reaches PACK_N-1 on accepted beat; emitted value includes that beat.
REQ-026 Emit latency: out_valid high the cycle after accepting beat; out_data/out_ch/out_ovf held stable while out_valid & ~out_ready.
REQ-027 On emit the channel's accumulator, lane counter, non-empty and overflow flags return to 0 in same edge.
REQ-028 PACK partial emit (in_last before PACK_N beats): unfilled upper lanes are 0.
REQ-029 Output register one-deep; out_valid falls after out_valid & out_ready unless a new emit loads same edge (back-to-back, full throughput).
REQ-030 FSM states RUN, FLUSH. RUN->FLUSH on flush pulse (beat accepted same cycle is processed first). FLUSH scans channels 0..NCH-1, one per cycle when output register free, emitting non-empty channels, skipping empty ones; FLUSH->RUN after channel NCH-1 handled.
REQ-031 flush while in FLUSH ignored; flush with all channels empty returns to RUN after NCH scan cycles, no output.
REQ-032 clear: zeros all channel state next edge, forces FSM to RUN, beat in that cycle not accepted; output register and pending out_valid unaffected.
REQ-033 Accumulator arithmetic unsigned; no sign extension.

Reset
REQ-034 While rst low: out_valid 0, out_data 0, out_ch 0, out_ovf 0, busy 0, all channel state 0, FSM RUN.
REQ-035 Reset mid-operation discards pending output and all partial sums immediately (asynchronous); in_ready 1 on first cycle after release.

Verification (DATA_W=8, NCH=4, PACK_N=4, OUT_W=32, SAT=1)
REQ-036 ACC, ch1 beats 0x10,0x20,0x30(last) -> next cycle out_valid, out_ch=1, out_data=0x00000060, out_ovf=0.
REQ-037 PACK, ch2 beats 0x11,0x22,0x33,0x44 (no last) -> out_data=0x44332211, out_ch=2; then 0xAA(last) -> out_data=0x000000AA.
REQ-038 ACC ch0 preloaded to 0xFFFFFFF0, beat 0x20(last) -> out_data=0xFFFFFFFF, out_ovf=1; with SAT=0 -> 0x00000010, out_ovf=1.
REQ-039 out_ready held low 3 cycles with pending result -> in_ready 0, out_data stable; interleaved ch0/ch3 beats resume correctly after release.
REQ-040 ch0 and ch3 partial, flush pulse -> busy high, two results (ch0 then ch3), busy low after 4 scan cycles; clear mid-stream -> subsequent sums start from 0.

Source files
------------

// File: rtl/acc_out_pack.sv
// acc_out_pack: per-channel accumulate (ACC) or beat-concatenate (PACK) unit
// with a one-deep output register and a flush scanner that drains every
// non-empty channel in ascending channel order.
module acc_out_pack #(
    parameter int DATA_W = 32,
    parameter int NCH    = 4,
    parameter int PACK_N = 2,
    parameter int SAT    = 1,
    localparam int CH_W  = $clog2(NCH),
    localparam int OUT_W = PACK_N * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_i,
    input  logic              clear_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CH_W-1:0]   in_ch_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic [CH_W-1:0]   out_ch_o,
    output logic              out_ovf_o,
    output logic              busy_o
);

    localparam int LANE_W = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_N - 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     scan_q, scan_d;

    logic [OUT_W-1:0]    acc_q  [NCH];
    logic [OUT_W-1:0]    acc_d  [NCH];
    logic [LANE_W-1:0]   lane_q [NCH];
    logic [LANE_W-1:0]   lane_d [NCH];
    logic [NCH-1:0]      ne_q, ne_d;
    logic [NCH-1:0]      ovf_q, ovf_d;

    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic                out_ovf_q, out_ovf_d;

    logic                out_free, accept, beat_emit, scan_emit;
    logic [OUT_W-1:0]    cur_acc, pack_v, beat_acc;
    logic [LANE_W-1:0]   cur_lane;
    logic [OUT_W:0]      sum;
    logic                beat_ovf;

    assign out_free  = ~out_valid_q | out_ready_i;
    assign accept    = in_valid_i & in_ready_o;
    assign scan_emit = (state_q == ST_FLUSH) & ~clear_i & out_free & ne_q[scan_q];

    // FSM state register and flush scan pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            scan_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its peers.
            state_q <= state_d;
            scan_q  <= scan_d;
        end
    end

    // FSM next state: enter FLUSH on a pulse, leave after the last channel.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        state_d = state_q;
        scan_d  = scan_q;
        if (clear_i) begin
            state_d = ST_RUN;
            scan_d  = '0;
        end else if (state_q == ST_RUN) begin
            scan_d = '0;
            if (flush_i) state_d = ST_FLUSH;
        end else if (out_free) begin
            scan_d = scan_q + CH_W'(1);
            if (scan_q == CH_W'(NCH - 1)) state_d = ST_RUN;
        end
    end

    // FSM outputs: busy during the scan, input handshake only in RUN.
    always_comb begin
        busy_o     = (state_q == ST_FLUSH);
        in_ready_o = (state_q == ST_RUN) & ~clear_i & out_free;
    end

    // Beat datapath: updated value of the addressed channel after this beat.
    always_comb begin
        cur_acc  = acc_q[in_ch_i];
        cur_lane = lane_q[in_ch_i];
        sum      = {1'b0, cur_acc} + {1'b0, OUT_W'(in_data_i)};
        pack_v   = cur_acc;
        for (int l = 0; l < PACK_N; l++) begin
            if (cur_lane == LANE_W'(l)) pack_v[l*DATA_W +: DATA_W] = in_data_i;
        end
        if (mode_i) begin
            beat_acc = pack_v;
            beat_ovf = 1'b0;
        end else begin
            beat_acc = (sum[OUT_W] && (SAT != 0)) ? '1 : sum[OUT_W-1:0];
            beat_ovf = ovf_q[in_ch_i] | sum[OUT_W];
        end
        beat_emit = accept & (in_last_i | (mode_i & (cur_lane == LAST_LANE)));
    end

    // Channel state next values: clear, beat update, or return to empty on emit.
    always_comb begin
        acc_d  = acc_q;
        lane_d = lane_q;
        ne_d   = ne_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            for (int c = 0; c < NCH; c++) begin
                acc_d[c]  = '0;
                lane_d[c] = '0;
            end
            ne_d  = '0;
            ovf_d = '0;
        end else begin
            if (accept) begin
                if (beat_emit) begin
                    acc_d[in_ch_i]  = '0;
                    lane_d[in_ch_i] = '0;
                    ne_d[in_ch_i]   = 1'b0;
                    ovf_d[in_ch_i]  = 1'b0;
                end else begin
                    acc_d[in_ch_i]  = beat_acc;
                    lane_d[in_ch_i] = mode_i ? cur_lane + LANE_W'(1) : cur_lane;
                    ne_d[in_ch_i]   = 1'b1;
                    ovf_d[in_ch_i]  = beat_ovf;
                end
            end
            if (scan_emit) begin
                acc_d[scan_q]  = '0;
                lane_d[scan_q] = '0;
                ne_d[scan_q]   = 1'b0;
                ovf_d[scan_q]  = 1'b0;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the channel arrays are flops, not RAM, because reset must
            // discard every partial sum at once.
            for (int c = 0; c < NCH; c++) begin
                acc_q[c]  <= '0;
                lane_q[c] <= '0;
            end
            ne_q  <= '0;
            ovf_q <= '0;
        end else begin
            acc_q  <= acc_d;
            lane_q <= lane_d;
            ne_q   <= ne_d;
            ovf_q  <= ovf_d;
        end
    end

    // Output register next values: load on emit, hold under back-pressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_ovf_d   = out_ovf_q;
        if (beat_emit) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_acc;
            out_ch_d    = in_ch_i;
            out_ovf_d   = beat_ovf;
        end else if (scan_emit) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q[scan_q];
            out_ch_d    = scan_q;
            out_ovf_d   = ovf_q[scan_q];
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_acc_out_pack.sv
// Directed bench for acc_out_pack (DATA_W=8, NCH=4, PACK_N=4, SAT=1), plus two
// narrow single-lane instances (OUT_W=8) that exercise saturate vs wrap overflow.
module tb_acc_out_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode, clear, flush, in_valid, in_last, out_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_ch;
    logic        in_ready, out_valid, out_ovf, busy;
    logic [31:0] out_data;
    logic [1:0]  out_ch;

    // Narrow instances share stimulus; channel 0, ACC mode, always ready.
    logic        s_in_valid, s_in_last, tie0, tie1;
    logic [7:0]  s_in_data;
    logic [1:0]  s_in_ch;
    logic        s_ready, s_valid, s_ovf, s_busy;
    logic [7:0]  s_data;
    logic [1:0]  s_ch;
    logic        w_ready, w_valid, w_ovf, w_busy;
    logic [7:0]  w_data;
    logic [1:0]  w_ch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    acc_out_pack #(.DATA_W(8), .NCH(4), .PACK_N(4), .SAT(1)) dut (
        .clk(clk), .rst(rst), .mode_i(mode), .clear_i(clear), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_ch_i(in_ch), .in_last_i(in_last), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_ch_o(out_ch),
        .out_ovf_o(out_ovf), .busy_o(busy)
    );

    acc_out_pack #(.DATA_W(8), .NCH(4), .PACK_N(1), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .mode_i(tie0), .clear_i(tie0), .flush_i(tie0),
        .in_valid_i(s_in_valid), .in_ready_o(s_ready), .in_data_i(s_in_data),
        .in_ch_i(s_in_ch), .in_last_i(s_in_last), .out_valid_o(s_valid),
        .out_ready_i(tie1), .out_data_o(s_data), .out_ch_o(s_ch),
        .out_ovf_o(s_ovf), .busy_o(s_busy)
    );

    acc_out_pack #(.DATA_W(8), .NCH(4), .PACK_N(1), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .mode_i(tie0), .clear_i(tie0), .flush_i(tie0),
        .in_valid_i(s_in_valid), .in_ready_o(w_ready), .in_data_i(s_in_data),
        .in_ch_i(s_in_ch), .in_last_i(s_in_last), .out_valid_o(w_valid),
        .out_ready_i(tie1), .out_data_o(w_data), .out_ch_o(w_ch),
        .out_ovf_o(w_ovf), .busy_o(w_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] data, input logic last);
        in_ch    = ch;
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_s(input logic [7:0] data, input logic last);
        s_in_data  = data;
        s_in_last  = last;
        s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=00000000", out_data); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL rst_out_ch got=%0d exp=0", out_ch); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL rst_out_ovf got=%b exp=0", out_ovf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        tick();
        tick();
        rst = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_acc();
        send(2'd1, 8'h10, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL acc_no_early got=%b exp=0", out_valid); end
        send(2'd1, 8'h20, 1'b0);
        send(2'd1, 8'h30, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL acc_valid got=%b exp=1", out_valid); end
        total++; if (out_ch !== 2'd1) begin bad++; $display("FAIL acc_ch got=%0d exp=1", out_ch); end
        total++; if (out_data !== 32'h00000060) begin bad++; $display("FAIL acc_data got=%h exp=00000060", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL acc_ovf got=%b exp=0", out_ovf); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL acc_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_pack();
        mode = 1'b1;
        clear_pulse();
        send(2'd2, 8'h11, 1'b0);
        send(2'd2, 8'h22, 1'b0);
        send(2'd2, 8'h33, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pack_no_early got=%b exp=0", out_valid); end
        send(2'd2, 8'h44, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pack_full_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 32'h44332211) begin bad++; $display("FAIL pack_full_data got=%h exp=44332211", out_data); end
        total++; if (out_ch !== 2'd2) begin bad++; $display("FAIL pack_full_ch got=%0d exp=2", out_ch); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL pack_ovf got=%b exp=0", out_ovf); end
        send(2'd2, 8'hAA, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pack_part_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 32'h000000AA) begin bad++; $display("FAIL pack_part_data got=%h exp=000000aa", out_data); end
        tick();
    endtask

    task automatic test_overflow();
        send_s(8'hF0, 1'b0);
        send_s(8'h20, 1'b1);
        total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL sat_valid got=%b exp=1", s_valid); end
        total++; if (s_data !== 8'hFF) begin bad++; $display("FAIL sat_data got=%h exp=ff", s_data); end
        total++; if (s_ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", s_ovf); end
        total++; if (w_data !== 8'h10) begin bad++; $display("FAIL wrap_data got=%h exp=10", w_data); end
        total++; if (w_ovf !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%b exp=1", w_ovf); end
        send_s(8'h05, 1'b1);
        total++; if (s_data !== 8'h05) begin bad++; $display("FAIL sat_after_data got=%h exp=05", s_data); end
        total++; if (s_ovf !== 1'b0) begin bad++; $display("FAIL sat_after_ovf got=%b exp=0", s_ovf); end
        total++; if (w_ovf !== 1'b0) begin bad++; $display("FAIL wrap_after_ovf got=%b exp=0", w_ovf); end
        tick();
    endtask

    task automatic test_backpressure();
        mode = 1'b0;
        clear_pulse();
        out_ready = 1'b0;
        send(2'd0, 8'h01, 1'b0);
        send(2'd3, 8'h02, 1'b0);
        send(2'd0, 8'h03, 1'b1);
        in_ch = 2'd3; in_data = 8'h10; in_last = 1'b1; in_valid = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (out_data !== 32'h00000004) begin bad++; $display("FAIL bp_hold_data[%0d] got=%h exp=00000004", i, out_data); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_ready[%0d] got=%b exp=0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_b2b_valid got=%b exp=1", out_valid); end
        total++; if (out_ch !== 2'd3) begin bad++; $display("FAIL bp_b2b_ch got=%0d exp=3", out_ch); end
        total++; if (out_data !== 32'h00000012) begin bad++; $display("FAIL bp_b2b_data got=%h exp=00000012", out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        logic       exp_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp_c [4] = '{2'd0, 2'd0, 2'd0, 2'd3};
        logic [31:0] exp_d [4] = '{32'h5, 32'h0, 32'h0, 32'h7};
        send(2'd0, 8'h05, 1'b0);
        send(2'd3, 8'h07, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy_start got=%b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            flush = (i == 1);
            tick();
            total++; if (out_valid !== exp_v[i]) begin bad++; $display("FAIL flush_valid[%0d] got=%b exp=%b", i, out_valid, exp_v[i]); end
            total++; if (busy !== exp_b[i]) begin bad++; $display("FAIL flush_busy[%0d] got=%b exp=%b", i, busy, exp_b[i]); end
            if (exp_v[i]) begin
                total++; if (out_ch !== exp_c[i]) begin bad++; $display("FAIL flush_ch[%0d] got=%0d exp=%0d", i, out_ch, exp_c[i]); end
                total++; if (out_data !== exp_d[i]) begin bad++; $display("FAIL flush_data[%0d] got=%h exp=%h", i, out_data, exp_d[i]); end
            end
        end
        flush = 1'b0;
        // All channels now empty: scan runs NCH cycles with no output.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL eflush_valid[%0d] got=%b exp=0", i, out_valid); end
            total++; if (busy !== exp_b[i]) begin bad++; $display("FAIL eflush_busy[%0d] got=%b exp=%b", i, busy, exp_b[i]); end
        end
    endtask

    task automatic test_clear();
        send(2'd1, 8'h40, 1'b0);
        out_ready = 1'b0;
        send(2'd2, 8'h0C, 1'b1);
        in_ch = 2'd1; in_data = 8'h08; in_valid = 1'b1; clear = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready got=%b exp=0", in_ready); end
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_keep_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 32'h0000000C) begin bad++; $display("FAIL clr_keep_data got=%h exp=0000000c", out_data); end
        out_ready = 1'b1;
        send(2'd1, 8'h03, 1'b1);
        total++; if (out_ch !== 2'd1) begin bad++; $display("FAIL clr_sum_ch got=%0d exp=1", out_ch); end
        total++; if (out_data !== 32'h00000003) begin bad++; $display("FAIL clr_sum_data got=%h exp=00000003", out_data); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(2'd2, 8'h09, 1'b0);
        send(2'd2, 8'h01, 1'b1);
        total++; if (out_data !== 32'h0000000A) begin bad++; $display("FAIL ar_pre_data got=%h exp=0000000a", out_data); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL ar_data got=%h exp=00000000", out_data); end
        tick();
        rst = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        send(2'd2, 8'h02, 1'b1);
        total++; if (out_data !== 32'h00000002) begin bad++; $display("FAIL ar_fresh_data got=%h exp=00000002", out_data); end
        tick();
    endtask

    initial begin
        mode = 1'b0; clear = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_ch = '0; out_ready = 1'b1;
        tie0 = 1'b0; tie1 = 1'b1;
        s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = '0; s_in_ch = '0;
        test_reset();
        test_acc();
        test_pack();
        test_overflow();
        test_backpressure();
        test_flush();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
